periph_bridge: RTL and testbench

//  Parametrised, registered CPU-to-peripheral bridge. It generalises the combinational address decoder to N_DEV devices with base/mask windows.
//  One access is outstanding at a time. Each access has a request/acknowledge handshake, per-device wait states via DEV_RDY,
//  a timeout, and a bus-error response for unmapped addresses.

---
 rtl/periph_bridge_pkg.sv | 23 ++
 rtl/periph_addr_dec.sv | 28 ++
 rtl/periph_bridge.sv | 143 ++++++++++++++
 tb/tb_periph_bridge.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/periph_bridge_pkg.sv
// Shared definitions for the CPU-to-peripheral bridge: FSM states, the
// error read-back word and the standard peripheral address map.
package periph_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP,
        ST_ERR
    } bridge_state_e;

    localparam logic [31:0] BUS_ERR_DATA = 32'h2333_3333;

    // Each peripheral owns a 16-byte window.
    localparam logic [31:0] WINDOW_MASK = 32'hFFFF_FFF0;
    localparam logic [31:0] TIMER0_BASE = 32'h0000_7F00;
    localparam logic [31:0] UART_BASE   = 32'h0000_7F10;
    localparam logic [31:0] SWITCH_BASE = 32'h0000_7F20;
    localparam logic [31:0] LED_BASE    = 32'h0000_7F30;
    localparam logic [31:0] DIGIT_BASE  = 32'h0000_7F40;
    localparam logic [31:0] TIMER1_BASE = 32'h0000_7F50;

endpackage

// File: rtl/periph_addr_dec.sv
// Combinational priority address decoder: maps a byte address onto one of
// N_DEV base/mask windows, lowest slot index winning on overlap.
module periph_addr_dec
    import periph_bridge_pkg::*;
#(
    parameter int                  N_DEV    = 6,
    parameter logic [N_DEV*32-1:0] DEV_BASE = {N_DEV{32'h0}},
    parameter logic [N_DEV*32-1:0] DEV_MASK = {N_DEV{WINDOW_MASK}}
) (
    input  logic [31:0]      addr,
    output logic             hit,
    output logic [N_DEV-1:0] sel
);

    // Walk from the highest slot down so a lower index overrides later.
    always_comb begin
        hit = 1'b0;
        sel = '0;
        for (int i = N_DEV - 1; i >= 0; i--) begin
            if ((addr & DEV_MASK[32*i +: 32]) == (DEV_BASE[32*i +: 32] & DEV_MASK[32*i +: 32])) begin
                hit    = 1'b1;
                sel    = '0;
                sel[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/periph_bridge.sv
// Registered CPU-to-peripheral bridge: one outstanding access with
// per-device wait states, a timeout and bus-error responses.
module periph_bridge
    import periph_bridge_pkg::*;
#(
    parameter int                  N_DEV    = 6,
    parameter logic [N_DEV*32-1:0] DEV_BASE = {N_DEV{32'h0}},
    parameter logic [N_DEV*32-1:0] DEV_MASK = {N_DEV{32'hFFFF_FFF0}},
    parameter int                  ADDR_W   = 5,
    parameter int                  TIMEOUT  = 16,
    parameter logic [31:0]         ERR_DATA = BUS_ERR_DATA
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  PrReq,
    input  logic [31:0]           PrAddr,
    input  logic                  PrWe,
    input  logic [3:0]            PrBE,
    input  logic [31:0]           PrWD,
    output logic [31:0]           PrRD,
    output logic                  PrAck,
    output logic                  PrErr,
    output logic                  PrBusy,
    output logic [N_DEV-1:0]      DEV_SEL,
    output logic [N_DEV-1:0]      DEV_WE,
    output logic [ADDR_W-3:0]     DEV_ADDR,
    output logic [3:0]            DEV_BE,
    output logic [31:0]           DEV_WD,
    input  logic [N_DEV*32-1:0]   DEV_RD,
    input  logic [N_DEV-1:0]      DEV_RDY
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    bridge_state_e      state_q, state_d;
    logic [N_DEV-1:0]   sel_q, sel_d;
    logic               we_q, we_d;
    logic [ADDR_W-3:0]  addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wd_q, wd_d;
    logic [31:0]        rd_q, rd_d;
    logic [TIMER_W-1:0] timer_q, timer_d;

    logic               dec_hit;
    logic [N_DEV-1:0]   dec_sel;
    logic [31:0]        sel_rd;

    periph_addr_dec #(
        .N_DEV    (N_DEV),
        .DEV_BASE (DEV_BASE),
        .DEV_MASK (DEV_MASK)
    ) u_dec (
        .addr (PrAddr),
        .hit  (dec_hit),
        .sel  (dec_sel)
    );

    always_comb begin
        sel_rd = '0;
        for (int i = 0; i < N_DEV; i++) begin
            if (sel_q[i]) begin
                sel_rd = DEV_RD[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wd_d    = wd_q;
        rd_d    = rd_q;
        timer_d = timer_q;
        case (state_q)
            ST_IDLE: begin
                if (PrReq) begin
                    sel_d   = dec_sel;
                    we_d    = PrWe;
                    addr_d  = PrAddr[ADDR_W-1:2];
                    be_d    = PrBE;
                    wd_d    = PrWD;
                    timer_d = TIMER_W'(1);
                    if (dec_hit) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_ERR;
                        rd_d    = ERR_DATA;
                    end
                end
            end
            ST_ACCESS: begin
                if ((sel_q & DEV_RDY) != '0) begin
                    state_d = ST_RESP;
                    rd_d    = we_q ? 32'h0 : sel_rd;
                end else if (timer_q == TIMER_W'(TIMEOUT)) begin
                    state_d = ST_ERR;
                    rd_d    = ERR_DATA;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            ST_ERR:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wd_q    <= '0;
            rd_q    <= '0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wd_q    <= wd_d;
            rd_q    <= rd_d;
            timer_q <= timer_d;
        end
    end

    // Strobes decode straight from the state flop so a reset kills them at once.
    assign DEV_SEL  = (state_q == ST_ACCESS) ? sel_q : '0;
    assign DEV_WE   = DEV_SEL & {N_DEV{we_q}};
    assign DEV_ADDR = addr_q;
    assign DEV_BE   = be_q;
    assign DEV_WD   = wd_q;
    assign PrRD     = rd_q;
    assign PrAck    = (state_q == ST_RESP) || (state_q == ST_ERR);
    assign PrErr    = (state_q == ST_ERR);
    assign PrBusy   = (state_q != ST_IDLE);

endmodule

// File: tb/tb_periph_bridge.sv
// Directed bench for periph_bridge: a table of single accesses plus
// hand-written stall, timeout, back-to-back and reset-abort sequences.
module tb_periph_bridge;
    import periph_bridge_pkg::*;

    localparam int N_DEV = 6;
    // Slot 5 is a wide catch-all window over the whole 0x7Fxx page.
    localparam logic [N_DEV*32-1:0] BASES = {32'h0000_7F00, DIGIT_BASE, LED_BASE,
                                             SWITCH_BASE, UART_BASE, TIMER0_BASE};
    localparam logic [N_DEV*32-1:0] MASKS = {32'hFFFF_FF00, WINDOW_MASK, WINDOW_MASK,
                                             WINDOW_MASK, WINDOW_MASK, WINDOW_MASK};

    logic         clk = 1'b0;
    logic         reset;
    logic         PrReq;
    logic [31:0]  PrAddr;
    logic         PrWe;
    logic [3:0]   PrBE;
    logic [31:0]  PrWD;
    logic [31:0]  PrRD;
    logic         PrAck, PrErr, PrBusy;
    logic [5:0]   DEV_SEL, DEV_WE;
    logic [2:0]   DEV_ADDR;
    logic [3:0]   DEV_BE;
    logic [31:0]  DEV_WD;
    logic [191:0] dev_rd;
    logic [5:0]   dev_rdy;
    logic [31:0]  dev_rd_words [N_DEV];

    int total = 0;
    int bad   = 0;

    periph_bridge #(
        .N_DEV    (N_DEV),
        .DEV_BASE (BASES),
        .DEV_MASK (MASKS),
        .ADDR_W   (5),
        .TIMEOUT  (16),
        .ERR_DATA (32'h2333_3333)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .PrReq    (PrReq),
        .PrAddr   (PrAddr),
        .PrWe     (PrWe),
        .PrBE     (PrBE),
        .PrWD     (PrWD),
        .PrRD     (PrRD),
        .PrAck    (PrAck),
        .PrErr    (PrErr),
        .PrBusy   (PrBusy),
        .DEV_SEL  (DEV_SEL),
        .DEV_WE   (DEV_WE),
        .DEV_ADDR (DEV_ADDR),
        .DEV_BE   (DEV_BE),
        .DEV_WD   (DEV_WD),
        .DEV_RD   (dev_rd),
        .DEV_RDY  (dev_rdy)
    );

    always #5 clk = ~clk;

    always_comb begin
        dev_rd = '0;
        for (int i = 0; i < N_DEV; i++) dev_rd[32*i +: 32] = dev_rd_words[i];
    end

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wd;
        int          exp_lat;
        logic [5:0]  exp_sel;
        logic        exp_err;
        logic [31:0] exp_rd;
        logic [2:0]  exp_daddr;
    } vec_t;

    vec_t vecs [8];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    // Issues one request and watches it until PrAck or the cycle limit.
    task automatic applyStimulus(
        input  logic [31:0] addr, input logic we, input logic [3:0] be, input logic [31:0] wd,
        input  int stall_slot, input int stall_cycles, input logic [31:0] release_data, input int limit,
        output int lat, output int sel_cycles, output logic [5:0] sel_or, output logic [5:0] we_or,
        output logic err, output logic [31:0] rd, output logic [2:0] daddr,
        output logic [3:0] dbe, output logic [31:0] dwd, output logic [5:0] sel_at_ack);
        lat = 0; sel_cycles = 0; sel_or = '0; we_or = '0; err = 1'b0; rd = '0;
        daddr = '0; dbe = '0; dwd = '0; sel_at_ack = '0;
        if (stall_slot >= 0) dev_rdy[stall_slot] = 1'b0;
        @(negedge clk);
        PrReq = 1'b1; PrAddr = addr; PrWe = we; PrBE = be; PrWD = wd;
        @(posedge clk);
        #1 PrReq = 1'b0;
        for (int k = 1; k <= limit; k++) begin
            @(negedge clk);
            if (DEV_SEL != '0) sel_cycles++;
            sel_or |= DEV_SEL;
            we_or  |= DEV_WE;
            if (PrAck) begin
                lat = k; err = PrErr; rd = PrRD; daddr = DEV_ADDR;
                dbe = DEV_BE; dwd = DEV_WD; sel_at_ack = DEV_SEL;
                break;
            end
            if (stall_slot >= 0 && k == stall_cycles + 1) begin
                dev_rdy[stall_slot]      = 1'b1;
                dev_rd_words[stall_slot] = release_data;
            end
        end
        if (stall_slot >= 0) dev_rdy[stall_slot] = 1'b1;
    endtask

    int          lat, sel_cycles;
    logic [5:0]  sel_or, we_or, sel_at_ack;
    logic        err;
    logic [31:0] rd, dwd;
    logic [2:0]  daddr;
    logic [3:0]  dbe;
    int          acks, ack_first, ack_second;
    logic        busy3, busy4;

    initial begin
        vecs[0] = '{32'h0000_7F00, 1'b0, 4'hF, 32'h0,         2, 6'b000001, 1'b0, 32'h1234_5678, 3'b000};
        vecs[1] = '{32'h0000_7F14, 1'b1, 4'h3, 32'hCAFE_BABE, 2, 6'b000010, 1'b0, 32'h0,         3'b101};
        vecs[2] = '{32'h0000_7F28, 1'b0, 4'hF, 32'h0,         2, 6'b000100, 1'b0, 32'h2222_2222, 3'b010};
        vecs[3] = '{32'h0000_1000, 1'b0, 4'hF, 32'h0,         1, 6'b000000, 1'b1, 32'h2333_3333, 3'b000};
        vecs[4] = '{32'h0000_7F04, 1'b0, 4'hC, 32'h0,         2, 6'b000001, 1'b0, 32'h1234_5678, 3'b001};
        vecs[5] = '{32'h0000_7F80, 1'b0, 4'hF, 32'h0,         2, 6'b100000, 1'b0, 32'h5555_5555, 3'b000};
        vecs[6] = '{32'h0000_7F3C, 1'b1, 4'hF, 32'h0000_00FF, 2, 6'b001000, 1'b0, 32'h0,         3'b111};
        vecs[7] = '{32'h0000_2004, 1'b1, 4'h1, 32'h1357_9BDF, 1, 6'b000000, 1'b1, 32'h2333_3333, 3'b001};

        dev_rd_words[0] = 32'h1234_5678;
        dev_rd_words[1] = 32'h1111_1111;
        dev_rd_words[2] = 32'h2222_2222;
        dev_rd_words[3] = 32'h3333_3333;
        dev_rd_words[4] = 32'h4444_4444;
        dev_rd_words[5] = 32'h5555_5555;
        dev_rdy = '1;
        PrReq = 1'b0; PrAddr = '0; PrWe = 1'b0; PrBE = '0; PrWD = '0;
        reset = 1'b1;

        #12;
        checkOutput("reset PrRD",    PrRD,            32'h0);
        checkOutput("reset PrAck",   {31'h0, PrAck},  32'h0);
        checkOutput("reset PrErr",   {31'h0, PrErr},  32'h0);
        checkOutput("reset PrBusy",  {31'h0, PrBusy}, 32'h0);
        checkOutput("reset DEV_SEL", {26'h0, DEV_SEL}, 32'h0);
        checkOutput("reset DEV_WE",  {26'h0, DEV_WE},  32'h0);
        checkOutput("reset DEV_WD",  DEV_WD,          32'h0);
        @(negedge clk);
        reset = 1'b0;

        for (int v = 0; v < 8; v++) begin
            applyStimulus(vecs[v].addr, vecs[v].we, vecs[v].be, vecs[v].wd, -1, 0, 32'h0, 30,
                          lat, sel_cycles, sel_or, we_or, err, rd, daddr, dbe, dwd, sel_at_ack);
            checkOutput($sformatf("vec%0d latency", v),  lat, vecs[v].exp_lat);
            checkOutput($sformatf("vec%0d sel", v),      {26'h0, sel_or}, {26'h0, vecs[v].exp_sel});
            checkOutput($sformatf("vec%0d we", v),       {26'h0, we_or},
                        {26'h0, vecs[v].we ? vecs[v].exp_sel : 6'b0});
            checkOutput($sformatf("vec%0d selcyc", v),   sel_cycles, vecs[v].exp_err ? 0 : 1);
            checkOutput($sformatf("vec%0d err", v),      {31'h0, err}, {31'h0, vecs[v].exp_err});
            checkOutput($sformatf("vec%0d rd", v),       rd, vecs[v].exp_rd);
            checkOutput($sformatf("vec%0d dev_addr", v), {29'h0, daddr}, {29'h0, vecs[v].exp_daddr});
            checkOutput($sformatf("vec%0d dev_be", v),   {28'h0, dbe}, {28'h0, vecs[v].be});
            checkOutput($sformatf("vec%0d dev_wd", v),   dwd, vecs[v].wd);
        end

        // Slot 4 stalls three cycles; only the data on the ready cycle counts.
        dev_rd_words[4] = 32'hDEAD_0000;
        applyStimulus(32'h0000_7F44, 1'b0, 4'hF, 32'h0, 4, 3, 32'h4444_ABCD, 30,
                      lat, sel_cycles, sel_or, we_or, err, rd, daddr, dbe, dwd, sel_at_ack);
        checkOutput("stall latency", lat, 5);
        checkOutput("stall selcyc",  sel_cycles, 4);
        checkOutput("stall sel",     {26'h0, sel_or}, 32'h10);
        checkOutput("stall rd",      rd, 32'h4444_ABCD);
        checkOutput("stall err",     {31'h0, err}, 32'h0);
        dev_rd_words[4] = 32'h4444_4444;

        applyStimulus(32'h0000_7F20, 1'b0, 4'hF, 32'h0, 2, 1000, 32'h2222_2222, 40,
                      lat, sel_cycles, sel_or, we_or, err, rd, daddr, dbe, dwd, sel_at_ack);
        checkOutput("timeout latency",    lat, 17);
        checkOutput("timeout selcyc",     sel_cycles, 16);
        checkOutput("timeout err",        {31'h0, err}, 32'h1);
        checkOutput("timeout rd",         rd, 32'h2333_3333);
        checkOutput("timeout sel at ack", {26'h0, sel_at_ack}, 32'h0);

        applyStimulus(32'h0000_7F24, 1'b0, 4'hF, 32'h0, -1, 0, 32'h0, 30,
                      lat, sel_cycles, sel_or, we_or, err, rd, daddr, dbe, dwd, sel_at_ack);
        checkOutput("post-timeout latency", lat, 2);
        checkOutput("post-timeout rd",      rd, 32'h2222_2222);
        checkOutput("post-timeout err",     {31'h0, err}, 32'h0);

        // PrReq held high: the second request lands the cycle after the first ack.
        acks = 0; ack_first = 0; ack_second = 0; busy3 = 1'b1; busy4 = 1'b0;
        @(negedge clk);
        PrReq = 1'b1; PrAddr = 32'h0000_7F10; PrWe = 1'b0; PrBE = 4'hF;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (PrAck) begin
                acks++;
                if (acks == 1) ack_first = k;
                else ack_second = k;
            end
            if (k == 3) busy3 = PrBusy;
            if (k == 4) begin
                busy4 = PrBusy;
                PrReq = 1'b0;
            end
        end
        checkOutput("b2b ack count",  acks, 2);
        checkOutput("b2b first ack",  ack_first, 2);
        checkOutput("b2b second ack", ack_second, 5);
        checkOutput("b2b idle gap",   {31'h0, busy3}, 32'h0);
        checkOutput("b2b re-accept",  {31'h0, busy4}, 32'h1);

        // Reset during a stalled write must drop every strobe immediately.
        dev_rdy[3] = 1'b0;
        @(negedge clk);
        PrReq = 1'b1; PrAddr = 32'h0000_7F30; PrWe = 1'b1; PrBE = 4'hF; PrWD = 32'hA5A5_A5A5;
        @(posedge clk);
        #1 PrReq = 1'b0;
        @(negedge clk);
        checkOutput("abort we before", {26'h0, DEV_WE}, 32'h08);
        reset = 1'b1;
        #1;
        checkOutput("abort sel",  {26'h0, DEV_SEL}, 32'h0);
        checkOutput("abort we",   {26'h0, DEV_WE},  32'h0);
        checkOutput("abort busy", {31'h0, PrBusy},  32'h0);
        checkOutput("abort wd",   DEV_WD,           32'h0);
        @(negedge clk);
        reset = 1'b0;
        dev_rdy[3] = 1'b1;
        acks = 0; sel_cycles = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (PrAck) acks++;
            if (DEV_SEL != '0) sel_cycles++;
        end
        checkOutput("abort no ack",    acks, 0);
        checkOutput("abort no strobe", sel_cycles, 0);

        applyStimulus(32'h0000_7F00, 1'b0, 4'hF, 32'h0, -1, 0, 32'h0, 30,
                      lat, sel_cycles, sel_or, we_or, err, rd, daddr, dbe, dwd, sel_at_ack);
        checkOutput("post-reset latency", lat, 2);
        checkOutput("post-reset rd",      rd, 32'h1234_5678);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
